// File: rtl/count_sequencer.sv
// count_sequencer: self-test engine that loads, counts and checks a companion loadable up-counter.
// Ports: clk/rst (sync, active-high); start, seed, steps request a run; count_in reads the counter back;
// load, load_data, count_en, output_en drive the counter; busy, done, pass, observed, fail_cnt report status.
module count_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] steps,
  input  logic [WIDTH-1:0] count_in,
  output logic             load,
  output logic [WIDTH-1:0] load_data,
  output logic             count_en,
  output logic             output_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] observed,
  output logic [7:0]       fail_cnt
);
  typedef enum logic [2:0] {IDLE, LOAD, COUNT, SETTLE, SAMPLE, DONE} state_t;
  state_t state, next;
  logic [WIDTH-1:0] seed_q, steps_q, expected, rem;
  logic match;
  assign match = count_in == expected;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      seed_q   <= '0;
      steps_q  <= '0;
      expected <= '0;
      rem      <= '0;
      pass     <= 1'b0;
      observed <= '0;
      fail_cnt <= '0;
    end else begin
      state <= next;
      if (state == IDLE && start) begin
        seed_q   <= seed;
        steps_q  <= steps;
        expected <= seed + steps;
        pass     <= 1'b0;
      end
      if (state == LOAD) rem <= steps_q;
      if (state == COUNT) rem <= rem - 1'b1;
      if (state == SAMPLE) begin
        observed <= count_in;
        pass     <= match;
        if (!match && fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
      end
    end
  end
  // rem holds the COUNT cycles still to run including the current one, so leave on 1.
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? LOAD : IDLE;
      LOAD:    next = steps_q != '0 ? COUNT : SETTLE;
      COUNT:   next = rem == WIDTH'(1) ? SETTLE : COUNT;
      SETTLE:  next = SAMPLE;
      SAMPLE:  next = DONE;
      default: next = IDLE;
    endcase
  end
  assign load      = state == LOAD;
  assign load_data = load ? seed_q : '0;
  assign count_en  = state == COUNT;
  assign output_en = state == SETTLE || state == SAMPLE;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed, table-driven checks of count_sequencer against a behavioural counter.
module tb_count_sequencer;
  logic clk = 0, rst = 1, start = 0, fault = 0;
  logic [7:0] seed = 0, steps = 0, count_in, load_data, observed, fail_cnt, cnt;
  logic load, count_en, output_en, busy, done, pass;
  int checks = 0, errors = 0;

  count_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .steps(steps), .count_in(count_in),
    .load(load), .load_data(load_data), .count_en(count_en), .output_en(output_en),
    .busy(busy), .done(done), .pass(pass), .observed(observed), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk)
    if (rst) cnt <= 8'h00;
    else if (load) cnt <= load_data;
    else if (count_en) cnt <= cnt + 8'd1;
  assign count_in = fault ? 8'h00 : cnt;

  typedef struct {
    logic [7:0] seed;
    logic [7:0] steps;
    bit         fault;
    logic [7:0] obs;
    bit         pass;
    logic [7:0] fc;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Called at a negedge while IDLE; returns at a negedge in the first IDLE cycle after DONE.
  task automatic run(input logic [7:0] s, input logic [7:0] st, input bit f,
                     input logic [7:0] exp_obs, input bit exp_pass, input logic [7:0] exp_fc);
    int done_at = 0, bad = 0;
    fault = f; seed = s; steps = st; start = 1;
    for (int k = 1; k <= int'(st) + 20; k++) begin
      @(negedge clk);
      start = 0;
      if (load !== (k == 1)) bad++;
      if (k == 1 && load_data !== s) bad++;
      if (k != 1 && load_data !== 8'h00) bad++;
      if (count_en !== (k >= 2 && k <= int'(st) + 1)) bad++;
      if (output_en !== (k == int'(st) + 2 || k == int'(st) + 3)) bad++;
      if (busy !== 1'b1) bad++;
      if (done === 1'b1) begin done_at = k; break; end
    end
    chk("latency", done_at, int'(st) + 4);
    chk("ctrl", bad, 0);
    chk("observed", observed, exp_obs);
    chk("pass", pass, exp_pass);
    chk("fail_cnt", fail_cnt, exp_fc);
    @(negedge clk);
    chk("idle_after", {busy, done}, 0);
  endtask

  initial begin
    int dones, done_at;
    logic [7:0] fc, obs_at;
    logic pass_at;
    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b1, 8'h00};
    tbl[1] = '{8'hFE, 8'h04, 1'b0, 8'h02, 1'b1, 8'h00};
    tbl[2] = '{8'h42, 8'h00, 1'b0, 8'h42, 1'b1, 8'h00};
    tbl[3] = '{8'h10, 8'h02, 1'b1, 8'h00, 1'b0, 8'h01};
    tbl[4] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h01};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 8'h01};
    tbl[6] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 8'h02};

    repeat (2) @(negedge clk);
    chk("reset_outputs", {load, load_data, count_en, output_en, busy, done, pass, observed, fail_cnt}, 0);
    rst = 0;

    foreach (tbl[i]) run(tbl[i].seed, tbl[i].steps, tbl[i].fault, tbl[i].obs, tbl[i].pass, tbl[i].fc);

    fc = 8'h02;
    for (int i = 0; i < 300; i++) begin
      fc = fc == 8'hFF ? 8'hFF : fc + 8'd1;
      run(8'h10, 8'h00, 1'b1, 8'h00, 1'b0, fc);
    end
    chk("fail_cnt_sat", fail_cnt, 8'hFF);

    fault = 0; seed = 8'h00; steps = 8'h05; start = 1;
    dones = 0; done_at = 0; obs_at = 8'hAA; pass_at = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin dones++; done_at = k; obs_at = observed; pass_at = pass; end
      if (k == 10) chk("busy_ignore_idle", busy, 1'b0);
      start = (k == 3 || k == 9);
      seed  = start ? 8'h77 : 8'h00;
      steps = start ? 8'h02 : 8'h05;
    end
    chk("busy_dones", dones, 1);
    chk("busy_done_at", done_at, 9);
    chk("busy_observed", obs_at, 8'h05);
    chk("busy_pass", pass_at, 1'b1);

    seed = 8'h01; steps = 8'h06; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_outputs", {load, load_data, count_en, output_en, busy, done, pass, observed, fail_cnt}, 0);
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("abort_no_done", dones, 0);
    run(8'h01, 8'h06, 1'b0, 8'h07, 1'b1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
